// File: rtl/vid_gen_pkg.sv
// Shared encodings for the AXI4-Stream video test-pattern generator.
package vid_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HRAMP = 2'd0;
  localparam logic [1:0] MODE_VRAMP = 2'd1;
  localparam logic [1:0] MODE_CHK   = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

endpackage

// File: rtl/vid_gen_pix.sv
// Combinational single-pixel pattern generator: (mode, x, y, const_val) -> pixel.
module vid_gen_pix
  import vid_gen_pkg::*;
#(
  parameter int PIX_BITS = 8,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int CHK_LOG2 = 3
) (
  input  logic [1:0]          mode,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [PIX_BITS-1:0] const_val,
  output logic [PIX_BITS-1:0] pix
);

  logic x_bit;
  logic y_bit;

  // Square index parity; coordinates narrower than the square size are always in square 0.
  if (CHK_LOG2 < X_W) begin : g_xbit
    assign x_bit = x[CHK_LOG2];
  end else begin : g_xbit_zero
    assign x_bit = 1'b0;
  end

  if (CHK_LOG2 < Y_W) begin : g_ybit
    assign y_bit = y[CHK_LOG2];
  end else begin : g_ybit_zero
    assign y_bit = 1'b0;
  end

  always_comb begin
    pix = const_val;
    case (mode)
      MODE_HRAMP: pix = PIX_BITS'(x);
      MODE_VRAMP: pix = PIX_BITS'(y);
      MODE_CHK:   pix = (x_bit ^ y_bit) ? {PIX_BITS{1'b1}} : {PIX_BITS{1'b0}};
      default:    pix = const_val;
    endcase
  end

endmodule

// File: rtl/axis_vid_gen.sv
// AXI4-Stream video test-pattern generator with line/frame blanking and backpressure.
// Optional VID_GEN_FRAME_TAG_EN: pixel 0 of each start-of-frame beat carries frame_cnt.
module axis_vid_gen
  import vid_gen_pkg::*;
#(
  parameter int WDT       = 640,
  parameter int HGT       = 480,
  parameter int PIX_BITS  = 8,
  parameter int PPC       = 4,
  parameter int HBLK      = 64,
  parameter int VBLK      = 16,
  parameter int CHK_LOG2  = 3,
  parameter int TDEST_VAL = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enb,
  input  logic [1:0]                 mode,
  input  logic [PIX_BITS-1:0]        const_val,
  output logic                       tvalid,
  input  logic                       tready,
  output logic                       tuser,
  output logic                       tlast,
  output logic [PIX_BITS*PPC-1:0]    tdata,
  output logic [3:0]                 tdest,
  output logic [PIX_BITS*PPC/8-1:0]  tkeep,
  output logic                       busy,
  output logic [15:0]                frame_cnt,
  output logic                       frame_done
);

  localparam int X_W     = (WDT > 1) ? $clog2(WDT) : 1;
  localparam int Y_W     = (HGT > 1) ? $clog2(HGT) : 1;
  localparam int BLK_MAX = (HBLK > VBLK) ? HBLK : VBLK;
  localparam int BLK_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;
  localparam int DW      = PIX_BITS * PPC;

  localparam logic [X_W-1:0]   X_LAST    = X_W'(WDT - PPC);
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(HGT - 1);
  localparam logic [BLK_W-1:0] HBLK_LAST = BLK_W'((HBLK > 0) ? HBLK - 1 : 0);
  localparam logic [BLK_W-1:0] VBLK_LAST = BLK_W'((VBLK > 0) ? VBLK - 1 : 0);

  state_e                state_q, state_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [PIX_BITS-1:0]   const_q, const_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tuser_q, tuser_d;
  logic                  tlast_q, tlast_d;
  logic [DW-1:0]         tdata_q, tdata_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic                  line_end;
  logic                  vblank_end;
  logic                  start;

  logic [X_W-1:0]        pix_x [PPC];
  logic [PIX_BITS-1:0]   pix   [PPC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      blk_q        <= '0;
      frame_cnt_q  <= '0;
      mode_q       <= '0;
      const_q      <= '0;
      tvalid_q     <= 1'b0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      blk_q        <= blk_d;
      frame_cnt_q  <= frame_cnt_d;
      mode_q       <= mode_d;
      const_q      <= const_d;
      tvalid_q     <= tvalid_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    blk_d        = blk_q;
    frame_cnt_d  = frame_cnt_q;
    mode_d       = mode_q;
    const_d      = const_q;
    frame_done_d = 1'b0;
    line_end     = 1'b0;
    vblank_end   = 1'b0;
    start        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enb) start = 1'b1;
      end
      ST_ACTIVE: begin
        if (tready) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (HBLK > 0) begin
              state_d = ST_HBLANK;
              blk_d   = '0;
            end else begin
              line_end = 1'b1;
            end
          end else begin
            x_d = x_q + X_W'(PPC);
          end
        end
      end
      ST_HBLANK: begin
        if (blk_q == HBLK_LAST) line_end = 1'b1;
        else                    blk_d    = blk_q + BLK_W'(1);
      end
      ST_VBLANK: begin
        if (blk_q == VBLK_LAST) vblank_end = 1'b1;
        else                    blk_d      = blk_q + BLK_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Zero-length blanking collapses into the event that would have entered it.
    if (line_end) begin
      if (y_q == Y_LAST) begin
        y_d = '0;
        if (VBLK > 0) begin
          state_d = ST_VBLANK;
          blk_d   = '0;
        end else begin
          vblank_end = 1'b1;
        end
      end else begin
        y_d     = y_q + Y_W'(1);
        state_d = ST_ACTIVE;
      end
    end

    if (vblank_end) begin
      frame_done_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + 16'd1;
      if (enb) start   = 1'b1;
      else     state_d = ST_IDLE;
    end

    // mode/const_val are sampled only at frame start and held for the whole frame.
    if (start) begin
      state_d = ST_ACTIVE;
      x_d     = '0;
      y_d     = '0;
      mode_d  = mode;
      const_d = const_val;
    end
  end

  for (genvar k = 0; k < PPC; k++) begin : g_pix
    assign pix_x[k] = x_d + X_W'(k);

    vid_gen_pix #(
      .PIX_BITS (PIX_BITS),
      .X_W      (X_W),
      .Y_W      (Y_W),
      .CHK_LOG2 (CHK_LOG2)
    ) u_pix (
      .mode      (mode_d),
      .x         (pix_x[k]),
      .y         (y_d),
      .const_val (const_d),
      .pix       (pix[k])
    );
  end

  // Outputs are computed from next-state values so they are registered yet line up with the state.
  always_comb begin
    tvalid_d = (state_d == ST_ACTIVE);
    tuser_d  = tvalid_d && (x_d == '0) && (y_d == '0);
    tlast_d  = tvalid_d && (x_d == X_LAST);
    busy_d   = (state_d != ST_IDLE);
    tdata_d  = '0;
    if (tvalid_d) begin
      for (int k = 0; k < PPC; k++) begin
        tdata_d[k*PIX_BITS +: PIX_BITS] = pix[k];
      end
    end
`ifdef VID_GEN_FRAME_TAG_EN
    if (tuser_d) tdata_d[PIX_BITS-1:0] = PIX_BITS'(frame_cnt_d);
`endif
  end

  assign tvalid     = tvalid_q;
  assign tuser      = tuser_q;
  assign tlast      = tlast_q;
  assign tdata      = tdata_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;
  assign tdest      = 4'(TDEST_VAL);
  assign tkeep      = '1;

endmodule

// File: tb/tb_axis_vid_gen.sv
// Bench for axis_vid_gen: frame-level expected-beat model plus directed scenarios.
module tb_axis_vid_gen;

  localparam int WDT = 8, HGT = 4, PIX_BITS = 8, PPC = 2, HBLK = 2, VBLK = 3, CHK_LOG2 = 1;
  localparam int BPL = WDT / PPC;

  logic        clk = 1'b0;
  logic        rst_n, enb, tready;
  logic [1:0]  mode;
  logic [7:0]  const_val;
  logic        tvalid, tuser, tlast, busy, frame_done;
  logic [15:0] tdata, frame_cnt;
  logic [3:0]  tdest;
  logic [1:0]  tkeep;

  always #5 clk = ~clk;

  axis_vid_gen #(
    .WDT(WDT), .HGT(HGT), .PIX_BITS(PIX_BITS), .PPC(PPC),
    .HBLK(HBLK), .VBLK(VBLK), .CHK_LOG2(CHK_LOG2), .TDEST_VAL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enb(enb), .mode(mode), .const_val(const_val),
    .tvalid(tvalid), .tready(tready), .tuser(tuser), .tlast(tlast), .tdata(tdata),
    .tdest(tdest), .tkeep(tkeep), .busy(busy), .frame_cnt(frame_cnt), .frame_done(frame_done)
  );

  typedef struct {
    logic [15:0] data;
    logic        user;
    logic        last;
    logic        eof;
    int          gap;
  } beat_t;

  beat_t       expq[$];
  logic [15:0] log_data [64];
  logic        log_user [64];
  int          log_n;
  int          model_frames;
  int          exp_fidx;
  bit          rand_rdy;
  int          checks = 0;
  int          errors = 0;

  bit          armed;
  int          since_eof;
  int          idle_cnt;
  bit          pstall;
  logic [15:0] pdata;
  logic        puser, plast;
  beat_t       cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_model(int m, int px, int py, logic [7:0] cv);
    case (m)
      0:       return 8'(px);
      1:       return 8'(py);
      2:       return ((((px >> CHK_LOG2) ^ (py >> CHK_LOG2)) & 1) != 0) ? 8'hFF : 8'h00;
      default: return cv;
    endcase
  endfunction

  // Queue every beat of one frame; gap = idle cycles expected before the beat (-1: unknown).
  task automatic expect_frame(int m, logic [7:0] cv, bit b2b);
    beat_t b;
    for (int y = 0; y < HGT; y++) begin
      for (int bi = 0; bi < BPL; bi++) begin
        b.data = '0;
        for (int k = 0; k < PPC; k++) b.data[k*8 +: 8] = pix_model(m, bi*PPC + k, y, cv);
`ifdef VID_GEN_FRAME_TAG_EN
        if (bi == 0 && y == 0) b.data[7:0] = 8'(exp_fidx);
`endif
        b.user = (bi == 0 && y == 0);
        b.last = (bi == BPL - 1);
        b.eof  = (bi == BPL - 1) && (y == HGT - 1);
        if (bi > 0)      b.gap = 0;
        else if (y > 0)  b.gap = HBLK;
        else             b.gap = b2b ? HBLK + VBLK : -1;
        expq.push_back(b);
      end
    end
    exp_fidx++;
  endtask

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle compare against the expected-beat queue.
  initial begin
    armed = 0; since_eof = 0; idle_cnt = 0; pstall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expq.delete();
        armed = 0; since_eof = 0; idle_cnt = 0; pstall = 0; model_frames = 0;
        continue;
      end
      if (armed) begin
        since_eof++;
        if (since_eof == HBLK + VBLK + 1) begin
          chk("frame_done_pulse", frame_done, 1);
          chk("frame_cnt_inc", frame_cnt, 32'(16'(model_frames + 1)));
          model_frames++;
          armed = 0;
        end else begin
          chk("frame_done_early", frame_done, 0);
        end
      end else begin
        chk("frame_done_spurious", frame_done, 0);
      end
      if (pstall) begin
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, pdata);
        chk("stall_tuser", tuser, puser);
        chk("stall_tlast", tlast, plast);
      end
      if (!tvalid) begin
        chk("idle_tdata_zero", tdata, 0);
        idle_cnt++;
      end
      if (tvalid && tready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got tdata 0x%0h expected no beat", tdata);
        end else begin
          cur = expq.pop_front();
          chk("beat_tdata", tdata, cur.data);
          chk("beat_tuser", tuser, cur.user);
          chk("beat_tlast", tlast, cur.last);
          if (cur.gap >= 0) chk("beat_gap", idle_cnt, cur.gap);
          if (log_n < 64) begin
            log_data[log_n] = tdata;
            log_user[log_n] = tuser;
          end
          log_n++;
          if (cur.eof) begin
            armed = 1; since_eof = 0;
          end
        end
        idle_cnt = 0;
      end
      pstall = tvalid && !tready;
      pdata = tdata; puser = tuser; plast = tlast;
    end
  end

  task automatic wait_frames(int n);
    int t = 0;
    while (model_frames < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (model_frames < n) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", model_frames, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(int n);
    int t = 0;
    while (log_n < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (log_n < n) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", log_n, n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; enb = 1'b0; mode = 2'd0; const_val = 8'h5A;
    rand_rdy = 0; exp_fidx = 0; log_n = 0; model_frames = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("tdest_const", tdest, 0);
    chk("tkeep_ones", tkeep, 2'b11);

    // Two back-to-back h-ramp frames, full throughput.
    expect_frame(0, 8'h00, 0);
    expect_frame(0, 8'h00, 1);
    rst_n = 1'b1; enb = 1'b1; mode = 2'd0;
    wait_frames(1);
    chk("frame_cnt_first", frame_cnt, 1);
    enb = 1'b0;
    wait_frames(2);
    repeat (3) @(posedge clk);
    #1;
    chk("A_idle_busy", busy, 0);
    chk("A_idle_tvalid", tvalid, 0);
    chk("A_frame_cnt", frame_cnt, 2);
    chk("A_queue_empty", expq.size(), 0);
    chk("A_beat0", log_data[0], 16'h0100);
    chk("A_beat1", log_data[1], 16'h0302);
    chk("A_beat2", log_data[2], 16'h0504);
    chk("A_beat3", log_data[3], 16'h0706);
    chk("A_tuser0", log_user[0], 1);
    chk("A_tuser1", log_user[1], 0);
    chk("A_beats", log_n, 32);

    // Checkerboard under random backpressure.
    log_n = 0; rand_rdy = 1;
    expect_frame(2, 8'h00, 0);
    enb = 1'b1; mode = 2'd2;
    @(posedge clk); #1 enb = 1'b0;
    wait_frames(3);
    rand_rdy = 0;
`ifdef VID_GEN_FRAME_TAG_EN
    chk("B_beat0", log_data[0], 16'h0002);
`else
    chk("B_beat0", log_data[0], 16'h0000);
`endif
    chk("B_beat1", log_data[1], 16'hFFFF);
    chk("B_beat3", log_data[3], 16'hFFFF);
    chk("B_line2_beat0", log_data[8], 16'hFFFF);
    chk("B_line2_beat1", log_data[9], 16'h0000);
    chk("B_beats", log_n, 16);
    chk("B_queue_empty", expq.size(), 0);

    // enb and mode changed mid-frame: frame completes unchanged, then IDLE.
    log_n = 0;
    expect_frame(0, 8'h00, 0);
    enb = 1'b1; mode = 2'd0;
    wait_beats(5);
    enb = 1'b0; mode = 2'd1;
    wait_frames(4);
    repeat (4) @(posedge clk);
    #1;
    chk("C_idle_busy", busy, 0);
    chk("C_idle_tvalid", tvalid, 0);
    chk("C_hramp_beat5", log_data[5], 16'h0302);
    chk("C_queue_empty", expq.size(), 0);
    log_n = 0;
    expect_frame(1, 8'h00, 0);
    enb = 1'b1;
    @(posedge clk); #1 enb = 1'b0;
    wait_frames(5);
    chk("C_vramp_line2", log_data[8], 16'h0202);
    chk("C_vramp_line3", log_data[15], 16'h0303);
    chk("C_frame_cnt", frame_cnt, 5);

    // Asynchronous reset in the middle of a line.
    log_n = 0;
    expect_frame(3, 8'h5A, 0);
    const_val = 8'h5A; mode = 2'd3; enb = 1'b1;
    wait_beats(2);
    #2 rst_n = 1'b0;
    #1;
    chk("D_rst_tvalid", tvalid, 0);
    chk("D_rst_tdata", tdata, 0);
    chk("D_rst_tuser", tuser, 0);
    chk("D_rst_busy", busy, 0);
    chk("D_rst_frame_cnt", frame_cnt, 0);
    repeat (2) @(negedge clk);
    #1;
    exp_fidx = 0; log_n = 0; mode = 2'd0;
    expect_frame(0, 8'h00, 0);
    expect_frame(0, 8'h00, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_frames(1);
    enb = 1'b0;
    wait_frames(2);
    chk("D_restart_tuser", log_user[0], 1);
    chk("D_restart_beat0", log_data[0], 16'h0100);
`ifdef VID_GEN_FRAME_TAG_EN
    chk("D_frame2_beat0", log_data[16], 16'h0101);
`else
    chk("D_frame2_beat0", log_data[16], 16'h0100);
`endif
    chk("D_frame_cnt", frame_cnt, 2);
    chk("D_queue_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
